dk_audio_mixer: RTL and testbench

Final mixing stage of the discrete sound board. Consumes the signed 16-bit outputs of the per-effect discrete circuits (walk, jump, stomp, sample DAC, …) on each `audio_clk_en` sample tick, applies a per-channel unsigned gain, sums the results and saturates them to one signed 16-bit sample for the audio output path. A single time-multiplexed multiply-accumulate is used, sequenced by a small state machine, instead of one multiplier per channel.

---
 rtl/dk_audio_pkg.sv | 28 ++
 rtl/dk_audio_mixer.sv | 116 +++++++++++
 tb/tb_dk_audio_mixer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dk_audio_pkg.sv
// Shared definitions for the discrete sound board mixing stages.
// The sat16 clamp is reused by other stages that reduce a wide signed value to one sample.
package dk_audio_pkg;

    localparam int UNITY_GAIN     = 128;
    localparam int GAIN_FRAC_BITS = 7;
    localparam int SAT_IN_W       = 48;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } mixer_state_t;

    localparam logic signed [SAT_IN_W-1:0] S16_MAX = 32767;
    localparam logic signed [SAT_IN_W-1:0] S16_MIN = -32768;

    function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] acc);
        if (acc > S16_MAX) begin
            return 16'sh7fff;
        end else if (acc < S16_MIN) begin
            return 16'sh8000;
        end else begin
            return acc[15:0];
        end
    endfunction

endpackage

// File: rtl/dk_audio_mixer.sv
// Final mixer: per-channel Q1.7 gain, summed through one shared multiply-accumulate,
// then floored by the gain fraction and clamped to a signed 16-bit sample.
module dk_audio_mixer
    import dk_audio_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int GAIN_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         audio_clk_en,
    input  logic signed [15:0]           in   [NUM_CHANNELS],
    input  logic        [GAIN_WIDTH-1:0] gain [NUM_CHANNELS],
    output logic signed [15:0]           out,
    output logic                         out_valid,
    output logic                         overrun
);

    localparam int PROD_W = 16 + GAIN_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS) + 1;
    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    mixer_state_t                state_q, state_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic        [IDX_W-1:0]     idx_q, idx_d;
    logic signed [15:0]          out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overrun_q, overrun_d;
    logic                        snap_en;

    logic signed [15:0]          snap_in_q   [NUM_CHANNELS];
    logic        [GAIN_WIDTH-1:0] snap_gain_q [NUM_CHANNELS];

    logic signed [PROD_W-1:0]    in_ext, gain_ext, prod;
    logic signed [ACC_W-1:0]     shifted;
    logic signed [SAT_IN_W-1:0]  shifted_wide;

    // Operands are widened to the product width so the multiply maps to one DSP block.
    assign in_ext       = {{(PROD_W-16){snap_in_q[idx_q][15]}}, snap_in_q[idx_q]};
    assign gain_ext     = {{(PROD_W-GAIN_WIDTH){1'b0}}, snap_gain_q[idx_q]};
    assign prod         = in_ext * gain_ext;
    assign shifted      = acc_q >>> GAIN_FRAC_BITS;
    assign shifted_wide = {{(SAT_IN_W-ACC_W){shifted[ACC_W-1]}}, shifted};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        snap_en     = 1'b0;

        if (audio_clk_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    snap_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SAT: begin
                out_d       = sat16(shifted_wide);
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Snapshots are pure data and are only ever read after being loaded by a tick.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap_in_q   <= in;
            snap_gain_q <= gain;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dk_audio_mixer.sv
// Directed bench for dk_audio_mixer with the default four channels and 8-bit gain.
module tb_dk_audio_mixer;
    import dk_audio_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               audio_clk_en = 1'b0;
    logic signed [15:0] in_a   [4];
    logic        [7:0]  gain_a [4];
    logic signed [15:0] out;
    logic               out_valid;
    logic               overrun;

    int n_checks = 0;
    int n_pass   = 0;

    int                 pulses;
    int                 first_k;
    logic signed [15:0] out_seen;

    dk_audio_mixer #(.NUM_CHANNELS(4), .GAIN_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_clk_en (audio_clk_en),
        .in           (in_a),
        .gain         (gain_a),
        .out          (out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Tick at edge 0, optional second tick at edge tick2_at, optional input
    // scramble mid-MAC; observe 10 edges and record every out_valid pulse.
    task automatic run(input int tick2_at, input bit scramble,
                       output int n_pulse, output int k_first, output logic signed [15:0] o_val);
        n_pulse = 0;
        k_first = -1;
        o_val   = '0;
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        audio_clk_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            audio_clk_en = (k == tick2_at);
            if (scramble && k == 2) begin
                in_a   = '{16'sh7fff, 16'sh7fff, 16'sh7fff, 16'sh7fff};
                gain_a = '{8'd255, 8'd255, 8'd255, 8'd255};
            end
            @(posedge clk);
            @(negedge clk);
            audio_clk_en = 1'b0;
            if (out_valid) begin
                if (n_pulse == 0) begin
                    k_first = k;
                    o_val   = out;
                end
                n_pulse++;
            end
        end
    endtask

    initial begin
        in_a   = '{0, 0, 0, 0};
        gain_a = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_state", int'(dut.state_q), int'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Single channel at unity; pulse lands after the 5th edge past the tick edge.
        in_a   = '{10000, 0, 0, 0};
        gain_a = '{8'(UNITY_GAIN), 0, 0, 0};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("unity_pulses", pulses, 1);
        check("unity_latency", first_k, 5);
        check("unity_out", out_seen, 10000);
        check("unity_hold", out, 10000);

        // Four channels at unity, inputs scrambled during MAC must not matter.
        in_a   = '{6826, -2000, 1000, 0};
        gain_a = '{128, 128, 128, 128};
        run(0, 1'b1, pulses, first_k, out_seen);
        check("sum4_pulses", pulses, 1);
        check("sum4_out", out_seen, 5826);

        in_a   = '{20000, 20000, 20000, 20000};
        gain_a = '{255, 255, 255, 255};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("sat_pos", out_seen, 32767);

        in_a   = '{-32768, -32768, -32768, -32768};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("sat_neg", out_seen, -32768);

        in_a   = '{-3, 5, 5, 5};
        gain_a = '{64, 0, 0, 0};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("floor_neg", out_seen, -2);

        in_a[0] = 3;
        run(0, 1'b0, pulses, first_k, out_seen);
        check("floor_pos", out_seen, 1);

        in_a   = '{30000, -30000, 12345, -1};
        gain_a = '{0, 0, 0, 0};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("zero_gain_pulses", pulses, 1);
        check("zero_gain_out", out_seen, 0);
        check("no_overrun_yet", overrun, 0);

        // Second tick 3 clocks after the first: ignored, flagged.
        in_a   = '{500, 0, 0, 0};
        gain_a = '{128, 0, 0, 0};
        run(3, 1'b0, pulses, first_k, out_seen);
        check("ovr_pulses", pulses, 1);
        check("ovr_out", out_seen, 500);
        check("ovr_flag", overrun, 1);

        in_a[0] = 700;
        run(0, 1'b0, pulses, first_k, out_seen);
        check("ovr_next_out", out_seen, 700);
        check("ovr_sticky", overrun, 1);

        // Reset three edges into the sample.
        in_a[0] = 9999;
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", out, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_state", int'(dut.state_q), int'(IDLE));
        check("rst_mid_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_mid_no_pulse", pulses, 0);

        in_a   = '{0, 1234, 0, 0};
        gain_a = '{0, 128, 0, 0};
        run(0, 1'b0, pulses, first_k, out_seen);
        check("post_rst_out", out_seen, 1234);
        check("post_rst_latency", first_k, 5);

        // Tick landing on the SAT cycle is still an overrun.
        in_a[1] = 42;
        run(5, 1'b0, pulses, first_k, out_seen);
        check("sat_tick_pulses", pulses, 1);
        check("sat_tick_out", out_seen, 42);
        check("sat_tick_overrun", overrun, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
